// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode constants.
//
// Holds the next-PC selector and branch-compare encodings. The decoder drives
// npcMode/cmpMode with these values, and the fetch stage decodes them here.
// Also holds the reset PC default and small helpers for the PC datapath.
package fetch_stage_pkg;

  localparam int XLEN = 32;

  // Next-PC source select, which is 3 bits wide on the wire.
  // Codes 4..7 are reserved and behave like NPC_PC4.
  localparam logic [2:0] NPC_PC4    = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP   = 3'd2;  // j / jal
  localparam logic [2:0] NPC_JR     = 3'd3;

  // Branch condition select, which is 2 bits wide on the wire.
  localparam logic [1:0] CMP_EQ  = 2'd0;  // beq
  localparam logic [1:0] CMP_NE  = 2'd1;  // bne
  localparam logic [1:0] CMP_LEZ = 2'd2;  // blez
  localparam logic [1:0] CMP_GTZ = 2'd3;  // bgtz

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // Word offset of a branch: sign-extend imm16, then shift left by two.
  function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

  // Target of j/jal: the 256 MB region comes from the PC of the jump itself.
  function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0] pc,
                                                  input logic [25:0]     instr_index);
    return {pc[31:28], instr_index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_branch_cmp.sv
// Branch condition evaluator for the D-stage redirect decision.
//
// Ports:
//   rsVal   - forwarded rs operand
//   rtVal   - forwarded rt operand (used only by EQ and NE)
//   cmpMode - condition select (CMP_EQ / CMP_NE / CMP_LEZ / CMP_GTZ)
//   taken   - 1 when the selected condition holds
//
// All comparisons are signed 32-bit. LEZ and GTZ test rs against zero only.
module branch_cmp
  import fetch_stage_pkg::*;
(
  input  logic [XLEN-1:0] rsVal,
  input  logic [XLEN-1:0] rtVal,
  input  logic [1:0]      cmpMode,
  output logic            taken
);

  logic rs_is_zero;
  logic rs_is_neg;

  // Zero and sign flags are enough for both compares against zero.
  assign rs_is_zero = (rsVal == '0);
  assign rs_is_neg  = rsVal[XLEN-1];

  always_comb begin
    taken = 1'b0;
    case (cmpMode)
      CMP_EQ:  taken = (rsVal == rtVal);
      CMP_NE:  taken = (rsVal != rtVal);
      CMP_LEZ: taken = rs_is_neg || rs_is_zero;
      CMP_GTZ: taken = !rs_is_neg && !rs_is_zero;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: the PC register and the next-PC selection.
//
// Ports:
//   clk, reset    - rising-edge clock and synchronous active-high reset
//   stall         - hazard hold; the PC keeps its value at this edge
//   instr_D       - instruction in D; bits [25:0] give the jump index
//   PC_D          - PC of the instruction in D
//   imm16_D       - branch offset decoded in D
//   npcMode       - next-PC source (NPC_* codes; 4..7 behave as PC+4)
//   cmpMode       - branch condition (CMP_* codes)
//   rsVal_D       - forwarded rs value, used for compares and jr
//   rtVal_D       - forwarded rt value, used for compares
//   i_inst_addr   - instruction memory address (equals PC_F)
//   i_inst_rdata  - instruction memory data, combinational from i_inst_addr
//   instr_F       - fetched instruction passed to the D register
//   PC_F          - current fetch PC passed to the D register
//   branch_taken  - the D-stage redirect decision for this cycle
//
// Control flow has one delay slot. The word fetched during a redirect is
// PC_D+4, and it moves into D unchanged. The redirect only changes which PC
// loads at the next edge. PC_F is the only state in this stage.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [XLEN-1:0] instr_D,
  input  logic [XLEN-1:0] PC_D,
  input  logic [15:0]     imm16_D,
  input  logic [2:0]      npcMode,
  input  logic [1:0]      cmpMode,
  input  logic [XLEN-1:0] rsVal_D,
  input  logic [XLEN-1:0] rtVal_D,
  output logic [XLEN-1:0] i_inst_addr,
  input  logic [XLEN-1:0] i_inst_rdata,
  output logic [XLEN-1:0] instr_F,
  output logic [XLEN-1:0] PC_F,
  output logic            branch_taken
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] npc;
  logic            cond_true;

  // The opcode field of instr_D is decoded elsewhere. Only the index is used here.
  logic unused_instr_opcode;
  assign unused_instr_opcode = ^instr_D[31:26];

  branch_cmp u_branch_cmp (
    .rsVal   (rsVal_D),
    .rtVal   (rtVal_D),
    .cmpMode (cmpMode),
    .taken   (cond_true)
  );

  // The fall-through path uses PC_F. The branch target is relative to the
  // branch in D. Both additions wrap naturally at 32 bits.
  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = PC_D + 32'd4 + branch_offset(imm16_D);

  always_comb begin
    npc          = pc_plus4;
    branch_taken = 1'b0;
    case (npcMode)
      NPC_BRANCH: begin
        branch_taken = cond_true;
        if (cond_true) npc = branch_target;
      end
      NPC_JUMP: begin
        branch_taken = 1'b1;
        npc          = jump_target(PC_D, instr_D[25:0]);
      end
      NPC_JR: begin
        // The target is used as-is. A misaligned rs is the program's problem.
        branch_taken = 1'b1;
        npc          = rsVal_D;
      end
      default: begin
        npc          = pc_plus4;
        branch_taken = 1'b0;
      end
    endcase
  end

  // Reset overrides both stall and any pending redirect. On a stall the
  // redirect is not remembered: D holds its instruction, so the same
  // decision is recomputed next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (!stall) begin
      pc_q <= npc;
    end
  end

  assign PC_F        = pc_q;
  assign i_inst_addr = pc_q;
  assign instr_F     = i_inst_rdata;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. A reference model predicts PC_F from the
// architectural next-PC rules. A per-cycle compare checks PC_F,
// i_inst_addr, instr_F and branch_taken against that model. Literal
// expectations worked out by hand pin the model at each directed step.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] instr_D, PC_D, rsVal_D, rtVal_D;
  logic [15:0] imm16_D;
  logic [2:0]  npcMode;
  logic [1:0]  cmpMode;
  logic [31:0] i_inst_addr, i_inst_rdata, instr_F, PC_F;
  logic        branch_taken;

  always #5 clk = ~clk;

  // Instruction memory contents: an arbitrary word derived from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  assign i_inst_rdata = mem_word(i_inst_addr);

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .instr_D      (instr_D),
    .PC_D         (PC_D),
    .imm16_D      (imm16_D),
    .npcMode      (npcMode),
    .cmpMode      (cmpMode),
    .rsVal_D      (rsVal_D),
    .rtVal_D      (rtVal_D),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .instr_F      (instr_F),
    .PC_F         (PC_F),
    .branch_taken (branch_taken)
  );

  // ---------------- reference model ----------------
  int          checks = 0;
  int          errors = 0;
  logic        check_en = 1'b0;
  logic [31:0] model_pc;

  function automatic logic model_taken();
    int rs, rt;
    rs = int'(rsVal_D);
    rt = int'(rtVal_D);
    case (npcMode)
      3'd1: begin
        case (cmpMode)
          2'd0: return rs == rt;
          2'd1: return rs != rt;
          2'd2: return rs <= 0;
          default: return rs > 0;
        endcase
      end
      3'd2, 3'd3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_next();
    int off;
    if (!model_taken()) return model_pc + 32'd4;
    case (npcMode)
      3'd1: begin
        off = int'($signed(imm16_D)) * 4;
        return PC_D + 32'd4 + 32'(off);
      end
      3'd2: return (PC_D & 32'hF000_0000) | ((instr_D & 32'h03FF_FFFF) << 2);
      default: return rsVal_D;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset)       model_pc = RST_PC;
    else if (!stall) model_pc = model_next();
  end

  // ---------------- scoreboard / compare ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_pc_f", PC_F, model_pc);
      check("cyc_addr", i_inst_addr, model_pc);
      check("cyc_instr_f", instr_F, mem_word(model_pc));
      check("cyc_taken", {31'd0, branch_taken}, {31'd0, model_taken()});
    end
  end

  // ---------------- driver tasks ----------------
  // Advance one edge, then settle just after the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_d(input logic [2:0] mode, input logic [1:0] cmp,
                       input logic [31:0] pcd, input logic [15:0] imm,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] ins);
    npcMode = mode; cmpMode = cmp; PC_D = pcd; imm16_D = imm;
    rsVal_D = rs; rtVal_D = rt; instr_D = ins;
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; stall = 1'b0;
    set_d(3'd0, 2'd0, 32'h0, 16'h0, 32'h0, 32'h0, 32'h0);
    tick();
    check("reset_pc", i_inst_addr, 32'h0000_3000);
    check("reset_instr", instr_F, mem_word(32'h0000_3000));
    check("reset_taken", {31'd0, branch_taken}, 32'd0);
    check_en = 1'b1;

    reset = 1'b0;
    tick(); check("seq_3004", i_inst_addr, 32'h0000_3004);
    tick(); check("seq_3008", i_inst_addr, 32'h0000_3008);
    tick(); check("seq_300c", i_inst_addr, 32'h0000_300C);

    // beq taken backwards, then the same branch not taken
    set_d(3'd1, 2'd0, 32'h3010, 16'hFFFC, 32'd5, 32'd5, 32'h0);
    check("beq_taken_flag", {31'd0, branch_taken}, 32'd1);
    tick(); check("beq_target", i_inst_addr, 32'h0000_3004);
    set_d(3'd1, 2'd0, 32'h3010, 16'hFFFC, 32'd5, 32'd6, 32'h0);
    check("beq_not_taken_flag", {31'd0, branch_taken}, 32'd0);
    tick(); check("beq_fallthru", i_inst_addr, 32'h0000_3008);

    // j with instr_index 0xC40
    set_d(3'd2, 2'd0, 32'h3020, 16'h0, 32'h0, 32'h0, 32'h0800_0C40);
    tick(); check("jump_target", i_inst_addr, 32'h0000_3100);

    // jr held by two stall cycles
    set_d(3'd3, 2'd0, 32'h3100, 16'h0, 32'h0000_3abc, 32'h0, 32'h0);
    stall = 1'b1;
    tick(); check("jr_stall1", i_inst_addr, 32'h0000_3100);
    tick(); check("jr_stall2", i_inst_addr, 32'h0000_3100);
    stall = 1'b0;
    tick(); check("jr_target", i_inst_addr, 32'h0000_3abc);

    // signed compares against zero
    set_d(3'd1, 2'd3, 32'h3ab8, 16'h0010, 32'h8000_0000, 32'h0, 32'h0);
    check("gtz_min_flag", {31'd0, branch_taken}, 32'd0);
    tick(); check("gtz_min", i_inst_addr, 32'h0000_3ac0);
    set_d(3'd1, 2'd3, 32'h3abc, 16'h0002, 32'h1, 32'h0, 32'h0);
    tick(); check("gtz_one", i_inst_addr, 32'h0000_3ac8);
    set_d(3'd1, 2'd2, 32'h3ac0, 16'h0010, 32'h0, 32'hFFFF_FFFF, 32'h0);
    check("lez_zero_flag", {31'd0, branch_taken}, 32'd1);
    tick(); check("lez_zero", i_inst_addr, 32'h0000_3b04);
    set_d(3'd1, 2'd2, 32'h3b00, 16'h0010, 32'h5, 32'h0, 32'h0);
    tick(); check("lez_pos", i_inst_addr, 32'h0000_3b08);
    set_d(3'd1, 2'd1, 32'h3b04, 16'hFFFF, 32'h1, 32'h2, 32'h0);
    tick(); check("bne_taken", i_inst_addr, 32'h0000_3b04);

    // wrap-around on PC+4, reserved mode, upper-region jump, branch wrap
    set_d(3'd3, 2'd0, 32'h3b00, 16'h0, 32'hFFFF_FFFC, 32'h0, 32'h0);
    tick(); check("jr_top", i_inst_addr, 32'hFFFF_FFFC);
    set_d(3'd0, 2'd0, 32'h0, 16'h0, 32'h0, 32'h0, 32'h0);
    tick(); check("pc4_wrap", i_inst_addr, 32'h0000_0000);
    set_d(3'd5, 2'd0, 32'h3000, 16'h0, 32'h1234, 32'h1234, 32'h0);
    check("reserved_flag", {31'd0, branch_taken}, 32'd0);
    tick(); check("reserved_pc4", i_inst_addr, 32'h0000_0004);
    set_d(3'd2, 2'd0, 32'hA000_0010, 16'h0, 32'h0, 32'h0, 32'h0C00_0004);
    tick(); check("jump_region", i_inst_addr, 32'hA000_0010);
    set_d(3'd1, 2'd0, 32'hFFFF_FFF8, 16'h0001, 32'h0, 32'h0, 32'h0);
    tick(); check("branch_wrap", i_inst_addr, 32'h0000_0000);

    // reset beats stall and a taken branch
    set_d(3'd1, 2'd0, 32'h4000, 16'h0100, 32'h7, 32'h7, 32'h0);
    stall = 1'b1; reset = 1'b1;
    tick(); check("reset_override", i_inst_addr, 32'h0000_3000);
    check("reset_override_instr", instr_F, mem_word(32'h0000_3000));
    reset = 1'b0; stall = 1'b0;
    set_d(3'd0, 2'd0, 32'h0, 16'h0, 32'h0, 32'h0, 32'h0);
    tick(); check("post_reset", i_inst_addr, 32'h0000_3004);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
